// File: rtl/data_mem_if.sv
// Request/response bus between the MEM stage and the data memory controller.
interface data_mem_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output ready, done, rdata, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory with byte/half/word access, sign/zero extension, configurable
// wait states and an error response for misaligned, reserved or out-of-range
// requests. One transaction in flight; ready is high only in IDLE.
module data_mem_ctrl #(
    parameter int unsigned RAM_WORDS   = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    data_mem_if.slave  bus
);
    localparam int unsigned AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [32:0] BYTES = 33'(RAM_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [RAM_WORDS];

    logic          cur_we;
    logic [1:0]    cur_size;
    logic          cur_sext;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_val;
    logic [31:0]   wr_word;
    logic [3:0]    be;
    logic          acc_err;
    logic          access;
    logic          mem_we;

    // Request operands: with zero wait states the access happens on the very
    // accept edge, so in IDLE the live bus fields stand in for the latches.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = bus.we;
            cur_size  = bus.size;
            cur_sext  = bus.sign_ext;
            cur_addr  = bus.addr;
            cur_wdata = bus.wdata;
        end else begin
            cur_we    = we_q;
            cur_size  = size_q;
            cur_sext  = sext_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    // Error decode, lane selection for loads and byte enables for stores.
    always_comb begin
        idx     = cur_addr[AW+1:2];
        rd_word = mem[idx];
        rd_byte = rd_word[{cur_addr[1:0], 3'b000} +: 8];
        rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
        acc_err = (cur_size == 2'b11) ||
                  ((cur_size == 2'b01) && cur_addr[0]) ||
                  ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00)) ||
                  ({1'b0, cur_addr} >= BYTES);
        be      = '0;
        wr_word = cur_wdata;
        ld_val  = '0;
        case (cur_size)
            2'b00: begin
                be      = 4'b0001 << cur_addr[1:0];
                wr_word = {4{cur_wdata[7:0]}};
                ld_val  = {{24{cur_sext & rd_byte[7]}}, rd_byte};
            end
            2'b01: begin
                be      = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{cur_wdata[15:0]}};
                ld_val  = {{16{cur_sext & rd_half[15]}}, rd_half};
            end
            2'b10: begin
                be      = 4'b1111;
                ld_val  = rd_word;
            end
            default: begin
                be      = '0;
                ld_val  = '0;
            end
        endcase
    end

    // Next-state, request latching and response generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    size_d  = bus.size;
                    sext_d  = bus.sign_ext;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        access  = (state_d == RESP);
        mem_we  = access && cur_we && !acc_err && !reset;
        done_d  = access;
        err_d   = access && acc_err;
        rdata_d = (access && !cur_we && !acc_err) ? ld_val : '0;
    end

    // State, request latches and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (mem_we && be[k]) begin
                mem[idx][8*k +: 8] <= wr_word[8*k +: 8];
            end
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (0 and 3 wait states) checked every
// cycle against a byte-array model, plus directed literal expectations.
module tb_data_mem_ctrl;
    localparam int unsigned W0 = 0;
    localparam int unsigned W1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst      [2];
    logic        req_i    [2];
    logic        we_i     [2];
    logic [1:0]  size_i   [2];
    logic        sx_i     [2];
    logic [31:0] addr_i   [2];
    logic [31:0] wdata_i  [2];
    logic        ready_o  [2];
    logic        done_o   [2];
    logic        err_o    [2];
    logic [31:0] rdata_o  [2];

    data_mem_if bus0();
    data_mem_if bus1();

    assign bus0.req = req_i[0];    assign bus1.req = req_i[1];
    assign bus0.we = we_i[0];      assign bus1.we = we_i[1];
    assign bus0.size = size_i[0];  assign bus1.size = size_i[1];
    assign bus0.sign_ext = sx_i[0]; assign bus1.sign_ext = sx_i[1];
    assign bus0.addr = addr_i[0];  assign bus1.addr = addr_i[1];
    assign bus0.wdata = wdata_i[0]; assign bus1.wdata = wdata_i[1];
    assign ready_o[0] = bus0.ready; assign ready_o[1] = bus1.ready;
    assign done_o[0] = bus0.done;   assign done_o[1] = bus1.done;
    assign err_o[0] = bus0.err;     assign err_o[1] = bus1.err;
    assign rdata_o[0] = bus0.rdata; assign rdata_o[1] = bus1.rdata;

    data_mem_ctrl #(.RAM_WORDS(256), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset(rst[0]), .bus(bus0)
    );
    data_mem_ctrl #(.RAM_WORDS(256), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(rst[1]), .bus(bus1)
    );

    // ---------------- behavioural model ----------------
    logic [7:0]  mem_m  [2][1024];
    bit          pend   [2];
    int          due    [2];
    bit          m_we   [2];
    logic [1:0]  m_size [2];
    bit          m_sx   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    int          dones_m [2];
    int          dones_d [2];
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Executes the pending request of instance i on the byte array.
    function automatic void model_access(input int i, output bit e, output logic [31:0] r);
        int n;
        e = (m_size[i] == 2'd3) || (m_size[i] == 2'd1 && m_addr[i][0]) ||
            (m_size[i] == 2'd2 && m_addr[i][1:0] != 2'd0) || (m_addr[i] >= 32'd1024);
        r = '0;
        if (!e) begin
            n = 1 << m_size[i];
            for (int k = 0; k < n; k++) begin
                if (m_we[i]) mem_m[i][int'(m_addr[i]) + k] = m_wd[i][8*k +: 8];
                else         r = r | (32'(mem_m[i][int'(m_addr[i]) + k]) << (8*k));
            end
            if (!m_we[i] && m_sx[i] && n < 4 && r[8*n-1]) r = r | (32'hFFFFFFFF << (8*n));
        end
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        bit er, ed, e;
        logic [31:0] r;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                er = !pend[i];
                ed = pend[i] && (cyc == due[i]);
                chk($sformatf("ready%0d", i), 32'(ready_o[i]), 32'(er));
                chk($sformatf("done%0d", i), 32'(done_o[i]), 32'(ed));
                if (done_o[i] === 1'b1) dones_d[i]++;
                if (ed) begin
                    model_access(i, e, r);
                    dones_m[i]++;
                    chk($sformatf("err%0d", i), 32'(err_o[i]), 32'(e));
                    chk($sformatf("rdata%0d", i), rdata_o[i], r);
                    pend[i] = 1'b0;
                end else begin
                    chk($sformatf("rdata_idle%0d", i), rdata_o[i], 32'h0);
                end
                if (rst[i]) begin
                    pend[i] = 1'b0;
                end else if (er && req_i[i]) begin
                    pend[i]   = 1'b1;
                    due[i]    = cyc + 1 + ((i == 0) ? int'(W0) : int'(W1));
                    m_we[i]   = we_i[i];
                    m_size[i] = size_i[i];
                    m_sx[i]   = sx_i[i];
                    m_addr[i] = addr_i[i];
                    m_wd[i]   = wdata_i[i];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; returns the response and the cycles between
    // the accept edge and the done cycle beyond the first.
    task automatic xact(input int sel, input bit we, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output bit e, output logic [31:0] r, output int lat);
        int n;
        n = 0;
        while (ready_o[sel] !== 1'b1 && n < 100) begin step(); n++; end
        chk("ready_wait", 32'(ready_o[sel]), 32'h1);
        req_i[sel] = 1'b1; we_i[sel] = we; size_i[sel] = sz;
        sx_i[sel] = sx; addr_i[sel] = a; wdata_i[sel] = wd;
        step();
        req_i[sel] = 1'b0;
        addr_i[sel] = $urandom; wdata_i[sel] = $urandom;
        size_i[sel] = 2'($urandom_range(0, 3)); we_i[sel] = 1'($urandom_range(0, 1));
        lat = 0;
        while (done_o[sel] !== 1'b1 && lat < 40) begin step(); lat++; end
        chk("done_seen", 32'(done_o[sel]), 32'h1);
        e = err_o[sel];
        r = rdata_o[sel];
        step();
    endtask

    task automatic rand_xact(input int sel);
        bit we, sx, e;
        logic [1:0] sz;
        logic [31:0] a, r;
        int mode, lat, s;
        s = $urandom_range(0, 9);
        sz = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
        mode = $urandom_range(0, 19);
        if (mode == 0)      a = ($urandom_range(0, 1) == 0) ? 32'd1024 + $urandom_range(0, 63)
                                                            : 32'hFFFFFFF0 + $urandom_range(0, 15);
        else if (mode < 3)  a = $urandom_range(0, 63);
        else                a = $urandom_range(0, 63) & ~((32'd1 << sz) - 32'd1);
        we = 1'($urandom_range(0, 1));
        sx = 1'($urandom_range(0, 1));
        xact(sel, we, sz, sx, a, $urandom, e, r, lat);
    endtask

    initial begin
        bit e;
        logic [31:0] r;
        int lat, a;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req_i[i] = 1'b0; we_i[i] = 1'b0; size_i[i] = '0;
            sx_i[i] = 1'b0; addr_i[i] = '0; wdata_i[i] = '0;
            pend[i] = 1'b0; due[i] = 0; dones_m[i] = 0; dones_d[i] = 0;
        end
        step();
        mon_en = 1'b1;
        chk("rst_ready0", 32'(ready_o[0]), 32'h1);
        chk("rst_done0", 32'(done_o[0]), 32'h0);
        chk("rst_rdata1", rdata_o[1], 32'h0);
        step(); step();
        rst[0] = 1'b0; rst[1] = 1'b0;
        step();

        // Word store/load, zero wait states.
        xact(0, 1, 2'd2, 0, 32'h10, 32'h8899AABB, e, r, lat);
        chk("st_lat", 32'(lat), 32'(W0));
        chk("st_rdata", r, 32'h0);
        xact(0, 0, 2'd2, 0, 32'h10, 32'h0, e, r, lat);
        chk("ld_word", r, 32'h8899AABB);
        chk("ld_err", 32'(e), 32'h0);
        chk("ld_lat", 32'(lat), 32'(W0));

        // Byte and halfword lanes.
        xact(0, 1, 2'd2, 0, 32'h20, 32'h0, e, r, lat);
        xact(0, 1, 2'd0, 0, 32'h21, 32'hABCDEFF5, e, r, lat);
        xact(0, 1, 2'd1, 0, 32'h22, 32'h99991234, e, r, lat);
        xact(0, 0, 2'd2, 0, 32'h20, 32'h0, e, r, lat);
        chk("lanes_word", r, 32'h1234F500);
        xact(0, 0, 2'd0, 1, 32'h21, 32'h0, e, r, lat);
        chk("ld_byte_sx", r, 32'hFFFFFFF5);
        xact(0, 0, 2'd0, 0, 32'h21, 32'h0, e, r, lat);
        chk("ld_byte_zx", r, 32'h000000F5);
        xact(0, 0, 2'd1, 1, 32'h22, 32'h0, e, r, lat);
        chk("ld_half_sx", r, 32'h00001234);

        // Error responses.
        xact(0, 0, 2'd1, 0, 32'h03, 32'h0, e, r, lat);
        chk("mis_half_err", 32'(e), 32'h1);
        chk("mis_half_rd", r, 32'h0);
        xact(0, 1, 2'd2, 0, 32'h04, 32'hCAFEF00D, e, r, lat);
        xact(0, 1, 2'd2, 0, 32'h06, 32'hFFFFFFFF, e, r, lat);
        chk("mis_word_err", 32'(e), 32'h1);
        xact(0, 0, 2'd2, 0, 32'h04, 32'h0, e, r, lat);
        chk("mis_word_nochg", r, 32'hCAFEF00D);
        xact(0, 0, 2'd3, 0, 32'h10, 32'h0, e, r, lat);
        chk("rsvd_err", 32'(e), 32'h1);
        xact(0, 0, 2'd2, 0, 32'h400, 32'h0, e, r, lat);
        chk("oor_err", 32'(e), 32'h1);
        chk("oor_rd", r, 32'h0);
        chk("oor_lat", 32'(lat), 32'(W0));

        // Three wait states: timing and ignored requests while busy.
        while (ready_o[1] !== 1'b1) step();
        req_i[1] = 1'b1; we_i[1] = 1'b1; size_i[1] = 2'd2; addr_i[1] = 32'h30; wdata_i[1] = 32'h11111111;
        a = cyc;
        step();
        chk("w3_acc_cycle", 32'(cyc), 32'(a + 1));
        addr_i[1] = 32'h34; wdata_i[1] = 32'h55555555;
        for (int k = 1; k <= 3; k++) begin
            chk("w3_busy_ready", 32'(ready_o[1]), 32'h0);
            chk("w3_busy_done", 32'(done_o[1]), 32'h0);
            step();
        end
        req_i[1] = 1'b0;
        chk("w3_resp_ready", 32'(ready_o[1]), 32'h0);
        chk("w3_resp_done", 32'(done_o[1]), 32'h1);
        chk("w3_resp_err", 32'(err_o[1]), 32'h0);
        step();
        chk("w3_ready_back", 32'(ready_o[1]), 32'h1);
        chk("w3_done_gone", 32'(done_o[1]), 32'h0);

        // Reset during a WAIT cycle aborts the store.
        req_i[1] = 1'b1; we_i[1] = 1'b1; size_i[1] = 2'd2; addr_i[1] = 32'h30; wdata_i[1] = 32'hDEADBEEF;
        step();
        req_i[1] = 1'b0;
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        chk("abort_ready", 32'(ready_o[1]), 32'h1);
        chk("abort_done", 32'(done_o[1]), 32'h0);
        chk("abort_rdata", rdata_o[1], 32'h0);
        repeat (4) step();
        xact(1, 0, 2'd2, 0, 32'h30, 32'h0, e, r, lat);
        chk("abort_nowrite", r, 32'h11111111);
        chk("w3_lat", 32'(lat), 32'(W1));
        xact(1, 0, 2'd2, 0, 32'h34, 32'h0, e, r, lat);
        chk("ignored_req_nowrite", 32'(r === 32'h55555555), 32'h0);

        // Random mix over preinitialised words 0..15.
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 16; w++)
                xact(i, 1, 2'd2, 0, 32'(w * 4), $urandom, e, r, lat);
        for (int n = 0; n < 1000; n++) rand_xact(0);
        for (int n = 0; n < 300; n++) rand_xact(1);

        repeat (3) step();
        chk("done_count0", 32'(dones_d[0]), 32'(dones_m[0]));
        chk("done_count1", 32'(dones_d[1]), 32'(dones_m[1]));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Next-generation data memory for the MIPS pipeline. Adds byte, halfword and word access with sign/zero extension, a req/done handshake and a configurable number of wait states. Adds an error response for misaligned, reserved-size or out-of-range accesses. It sits behind the MEM stage; the pipeline stalls while ready is low.

Parameters:
RAM_WORDS, 256, number of 32-bit words in the array; byte-address range is 0 .. RAM_WORDS*4-1
WAIT_CYCLES, 0, extra wait states per access, from 0 to 15

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req  input  1  access request; accepted only when ready=1
we  input  1  1 = store, 0 = load; sampled on accept
size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (error); sampled on accept
sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend; sampled on accept
addr  input  32  byte address; sampled on accept
wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]); sampled on accept
ready  output  1  1 when idle and able to accept a request
done  output  1  one-cycle pulse marking transaction completion
rdata  output  32  load result; valid only while done=1, 0 otherwise
err  output  1  valid with done: 1 = access rejected

Behaviour:
- States: IDLE, WAIT, RESP. ready = (state == IDLE).
- Reset (reset=1 at an edge): state=IDLE, wait counter=0, done=0, err=0, rdata=0.
- Reset does not clear memory contents.
- Reset mid-transaction aborts it. A store whose commit edge coincides with reset is not written (reset wins).
- Accept: in IDLE with req=1, latch we, size, sign_ext, addr and wdata.
- After accept: if WAIT_CYCLES=0, go to RESP; else load counter=WAIT_CYCLES and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 1, the next edge moves to RESP.
- Memory access (read sample and write commit) happens on the edge entering RESP.
- RESP lasts exactly one cycle with done=1, then returns to IDLE.
- Latency: accept at cycle N gives done=1 in cycle N+WAIT_CYCLES+1; ready is high again in cycle N+WAIT_CYCLES+2.
- Requests while ready=0 are ignored, not queued. Input changes while busy have no effect.
- Error conditions, checked on the latched request:
  - size=11
  - size=01 with addr[0]=1
  - size=10 with addr[1:0]!=00
  - addr >= RAM_WORDS*4
- On error: no write, rdata=0, err=1 with done. Timing is identical to a successful access.
- Word index is addr[31:2]. Little-endian: lane k = addr[1:0] maps to bits [8k+7:8k].
- Store byte: write wdata[7:0] to lane addr[1:0]; other lanes are unchanged.
- Store half: write wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
- Store word: write all lanes. On a store, rdata=0 with done.
- Load byte/half: extract the selected lane(s), then extend to 32 bits with bit 7 or bit 15 if sign_ext=1, else with zeros. Load word returns the full word.
- Back-to-back transactions are strictly ordered, so a load after a store to the same address returns the stored data.
- Memory power-up contents are undefined; the bench must write before reading.

Test Plan:
- Reset, WAIT_CYCLES=0: store word 0x8899AABB @0x10, then load word @0x10 → done one cycle after each accept, rdata=0x8899AABB, err=0.
- Byte/half lanes: word 0x00000000 @0x20; store byte 0xF5 @0x21, then store half 0x1234 @0x22; load word @0x20 → 0x1234F500. Load byte @0x21 with sign_ext=1 → 0xFFFFFFF5; with sign_ext=0 → 0x000000F5.
- Errors:
  - load half @0x03 → err=1, rdata=0
  - store word @0x06 → err=1, then load word @0x04 shows no change
  - size=11 → err=1
  - load @RAM_WORDS*4 (0x400) → err=1
- WAIT_CYCLES=3: accept at cycle 10 → ready=0 in cycles 11–14, done=1 in cycle 14, ready=1 in cycle 15. A req pulse held during cycles 11–13 is ignored.
- Reset in a WAIT cycle of a store of 0xDEADBEEF @0x30 (old value 0x11111111) → outputs return to reset values next cycle; a later load @0x30 returns 0x11111111.
- Random mix of 1000 accesses against a byte-array model → rdata and err match every done; exactly one done per accepted req.
